// File: rtl/sw_debouncer_pkg.sv
// Shared types and constants for the switch/button debouncer.
// Auto-repeat behaviour is selected by the SW_DEBOUNCER_AUTO_REPEAT_EN macro.
package sw_debouncer_pkg;

   typedef enum logic [1:0] {
      IDLE_LO = 2'd0,
      WAIT_HI = 2'd1,
      IDLE_HI = 2'd2,
      WAIT_LO = 2'd3
   } state_t;

   localparam int DEBOUNCE_CYCLES_DEF = 500000;
   localparam int REPEAT_CYCLES_DEF   = 12500000;

   // Width able to hold 0..n-1, never less than one bit.
   function automatic int cnt_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/debounce_ch.sv
// Single debounce channel: 2-flop synchronizer, debounce FSM with stability counter,
// registered level/rise/fall. Auto-repeat on rise when SW_DEBOUNCER_AUTO_REPEAT_EN is defined.
module debounce_ch
   import sw_debouncer_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int REPEAT_CYCLES   = REPEAT_CYCLES_DEF
) (
   input  logic clock,
   input  logic reset,
   input  logic raw,
   output logic level,
   output logic rise,
   output logic fall
);

   localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          s1, s;
   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          level_nxt, rise_nxt, fall_nxt;

`ifdef SW_DEBOUNCER_AUTO_REPEAT_EN
   localparam int            RW       = cnt_width(REPEAT_CYCLES);
   localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_CYCLES - 1);

   logic [RW-1:0] rcnt, rcnt_nxt;
`else
   // The repeat period has no effect in this build.
   logic unused_repeat;
   assign unused_repeat = (REPEAT_CYCLES < 1);
`endif

   // NOTE: non-blocking assignments make s1 and s a true two-stage pipeline;
   // blocking ones would collapse them into a single flop.
   always_ff @(posedge clock) begin
      if (reset) begin
         s1 <= 1'b0;
         s  <= 1'b0;
      end else begin
         s1 <= raw;
         s  <= s1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE_LO;
         cnt   <= '0;
         level <= 1'b0;
         rise  <= 1'b0;
         fall  <= 1'b0;
`ifdef SW_DEBOUNCER_AUTO_REPEAT_EN
         rcnt  <= '0;
`endif
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         level <= level_nxt;
         rise  <= rise_nxt;
         fall  <= fall_nxt;
`ifdef SW_DEBOUNCER_AUTO_REPEAT_EN
         rcnt  <= rcnt_nxt;
`endif
      end
   end

   // NOTE: every output of this block gets a default first so no path leaves
   // one unassigned, which would otherwise infer a latch.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      level_nxt = level;
      rise_nxt  = 1'b0;
      fall_nxt  = 1'b0;
`ifdef SW_DEBOUNCER_AUTO_REPEAT_EN
      rcnt_nxt  = '0;
`endif
      case (state)
         IDLE_LO: begin
            if (s) begin
               state_nxt = WAIT_HI;
               cnt_nxt   = '0;
            end
         end
         WAIT_HI: begin
            if (!s) begin
               state_nxt = IDLE_LO;
               cnt_nxt   = '0;
            end else if (cnt == CNT_LAST) begin
               state_nxt = IDLE_HI;
               cnt_nxt   = '0;
               level_nxt = 1'b1;
               rise_nxt  = 1'b1;
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         IDLE_HI: begin
            if (!s) begin
               state_nxt = WAIT_LO;
               cnt_nxt   = '0;
            end else begin
`ifdef SW_DEBOUNCER_AUTO_REPEAT_EN
               // Leaving takes priority over a repeat due on the same edge.
               if (rcnt == RPT_LAST) begin
                  rise_nxt = 1'b1;
                  rcnt_nxt = '0;
               end else begin
                  rcnt_nxt = rcnt + RW'(1);
               end
`endif
            end
         end
         WAIT_LO: begin
            if (s) begin
               state_nxt = IDLE_HI;
               cnt_nxt   = '0;
            end else if (cnt == CNT_LAST) begin
               state_nxt = IDLE_LO;
               cnt_nxt   = '0;
               level_nxt = 1'b0;
               fall_nxt  = 1'b1;
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         default: begin
            state_nxt = IDLE_LO;
            cnt_nxt   = '0;
         end
      endcase
   end

endmodule

// File: rtl/sw_debouncer.sv
// Multi-channel switch/button conditioner: N_CH independent debounce channels.
// Optional auto-repeat on rise is enabled by defining SW_DEBOUNCER_AUTO_REPEAT_EN.
module sw_debouncer
   import sw_debouncer_pkg::*;
#(
   parameter int N_CH            = 3,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int REPEAT_CYCLES   = REPEAT_CYCLES_DEF
) (
   input  logic            clock,
   input  logic            reset,
   input  logic [N_CH-1:0] raw,
   output logic [N_CH-1:0] level,
   output logic [N_CH-1:0] rise,
   output logic [N_CH-1:0] fall
);

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      debounce_ch #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .REPEAT_CYCLES   (REPEAT_CYCLES)
      ) u_ch (
         .clock (clock),
         .reset (reset),
         .raw   (raw[g]),
         .level (level[g]),
         .rise  (rise[g]),
         .fall  (fall[g])
      );
   end

endmodule

// File: tb/tb_sw_debouncer.sv
// Bench for sw_debouncer: directed vector table followed by random stimulus against a
// run-length reference model. Honours SW_DEBOUNCER_AUTO_REPEAT_EN like the RTL.
module tb_sw_debouncer;

   localparam int N_CH = 3;
   localparam int DB   = 4;
   localparam int RP   = 8;

   logic            clock = 1'b0;
   logic            reset;
   logic [N_CH-1:0] raw;
   logic [N_CH-1:0] level, rise, fall;

   always #5 clock = ~clock;

   sw_debouncer #(
      .N_CH            (N_CH),
      .DEBOUNCE_CYCLES (DB),
      .REPEAT_CYCLES   (RP)
   ) dut (
      .clock (clock),
      .reset (reset),
      .raw   (raw),
      .level (level),
      .rise  (rise),
      .fall  (fall)
   );

   typedef struct {
      logic            rst;
      logic [N_CH-1:0] raw;
      logic [N_CH-1:0] lvl;
      logic [N_CH-1:0] rise;
      logic [N_CH-1:0] fall;
   } vec_t;

   vec_t tbl[$];
   int   checks = 0;
   int   errors = 0;

`ifdef SW_DEBOUNCER_AUTO_REPEAT_EN
   localparam logic [N_CH-1:0] REP0 = 3'b001;
`else
   localparam logic [N_CH-1:0] REP0 = 3'b000;
`endif

   // Reference model state: synchronizer delay line, accepted level, run lengths.
   logic [N_CH-1:0] m_s1, m_s, m_lvl;
   int              m_run  [N_CH];
   int              m_hold [N_CH];

   task automatic check(input string name, input logic [N_CH-1:0] act, input logic [N_CH-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push(input logic rst, input logic [N_CH-1:0] r, input logic [N_CH-1:0] l,
                       input logic [N_CH-1:0] ri, input logic [N_CH-1:0] f, input int n);
      vec_t v;
      v = '{rst, r, l, ri, f};
      for (int i = 0; i < n; i++) tbl.push_back(v);
   endtask

   task automatic drive(input logic rst, input logic [N_CH-1:0] r);
      @(negedge clock);
      reset = rst;
      raw   = r;
      @(posedge clock);
      #1;
   endtask

   task automatic model_reset();
      m_s1  = '0;
      m_s   = '0;
      m_lvl = '0;
      for (int c = 0; c < N_CH; c++) begin
         m_run[c]  = 0;
         m_hold[c] = 0;
      end
   endtask

   // A change is accepted once the synchronized input has disagreed with the
   // accepted level for DB+1 consecutive edges (entry edge plus DB stable counts).
   task automatic model_step(input logic [N_CH-1:0] r,
                             output logic [N_CH-1:0] er, output logic [N_CH-1:0] ef);
      logic seen;
      er = '0;
      ef = '0;
      for (int c = 0; c < N_CH; c++) begin
         seen    = m_s[c];
         m_s[c]  = m_s1[c];
         m_s1[c] = r[c];
         if (seen != m_lvl[c]) begin
            m_run[c]++;
            m_hold[c] = 0;
            if (m_run[c] == DB + 1) begin
               m_lvl[c] = seen;
               m_run[c] = 0;
               if (seen) er[c] = 1'b1;
               else      ef[c] = 1'b1;
            end
         end else if (m_run[c] > 0) begin
            m_run[c]  = 0;
            m_hold[c] = 0;
         end else if (m_lvl[c]) begin
`ifdef SW_DEBOUNCER_AUTO_REPEAT_EN
            m_hold[c]++;
            if (m_hold[c] == RP) begin
               er[c]     = 1'b1;
               m_hold[c] = 0;
            end
`endif
         end
      end
   endtask

   initial begin
      logic [N_CH-1:0] r, er, ef;
      reset = 1'b1;
      raw   = '0;

      // Reset with all inputs high, then first acceptance after deassertion.
      push(1, 3'b111, 3'b000, 3'b000, 3'b000, 2);
      push(0, 3'b111, 3'b000, 3'b000, 3'b000, 6);
      push(0, 3'b111, 3'b111, 3'b111, 3'b000, 1);
      push(0, 3'b111, 3'b111, 3'b000, 3'b000, 1);
      // Simultaneous release on all channels.
      push(0, 3'b000, 3'b111, 3'b000, 3'b000, 6);
      push(0, 3'b000, 3'b000, 3'b000, 3'b111, 1);
      push(0, 3'b000, 3'b000, 3'b000, 3'b000, 1);
      // Clean press on channel 0 held long enough to see repeats, then release.
      push(0, 3'b001, 3'b000, 3'b000, 3'b000, 6);
      push(0, 3'b001, 3'b001, 3'b001, 3'b000, 1);
      push(0, 3'b001, 3'b001, 3'b000, 3'b000, 7);
      push(0, 3'b001, 3'b001, REP0,   3'b000, 1);
      push(0, 3'b001, 3'b001, 3'b000, 3'b000, 7);
      push(0, 3'b001, 3'b001, REP0,   3'b000, 1);
      push(0, 3'b000, 3'b001, 3'b000, 3'b000, 6);
      push(0, 3'b000, 3'b000, 3'b000, 3'b001, 1);
      // Three-cycle glitch on channel 1 is rejected.
      push(0, 3'b010, 3'b000, 3'b000, 3'b000, 3);
      push(0, 3'b000, 3'b000, 3'b000, 3'b000, 6);
      // Bounce 1,0,1,0 on channel 2, then settle high.
      push(0, 3'b100, 3'b000, 3'b000, 3'b000, 1);
      push(0, 3'b000, 3'b000, 3'b000, 3'b000, 1);
      push(0, 3'b100, 3'b000, 3'b000, 3'b000, 1);
      push(0, 3'b000, 3'b000, 3'b000, 3'b000, 1);
      push(0, 3'b100, 3'b000, 3'b000, 3'b000, 6);
      push(0, 3'b100, 3'b100, 3'b100, 3'b000, 1);
      push(0, 3'b100, 3'b100, 3'b000, 3'b000, 3);
      // Release interrupted by reset mid-debounce: no fall pulse, level cleared.
      push(0, 3'b000, 3'b100, 3'b000, 3'b000, 4);
      push(1, 3'b000, 3'b000, 3'b000, 3'b000, 1);
      push(0, 3'b000, 3'b000, 3'b000, 3'b000, 8);

      foreach (tbl[i]) begin
         drive(tbl[i].rst, tbl[i].raw);
         check($sformatf("vec%0d level", i), level, tbl[i].lvl);
         check($sformatf("vec%0d rise", i),  rise,  tbl[i].rise);
         check($sformatf("vec%0d fall", i),  fall,  tbl[i].fall);
      end

      // Random stimulus: per-channel toggles give a mix of glitches and accepted changes.
      drive(1, '0);
      drive(1, '0);
      model_reset();
      r = '0;
      for (int n = 0; n < 4000; n++) begin
         for (int c = 0; c < N_CH; c++)
            if ($urandom_range(5) == 0) r[c] = ~r[c];
         drive(0, r);
         model_step(r, er, ef);
         check("rand level", level, m_lvl);
         check("rand rise",  rise,  er);
         check("rand fall",  fall,  ef);
         check("rand rise&fall exclusive", rise & fall, '0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sw_debouncer.md
Name: sw_debouncer

Overview:
- Input-side counterpart to the 7-segment display path: conditions raw slide-switch/pushbutton inputs (SW0..SWn) before they reach the counter and control logic.
- Per channel: 2-flop synchronizer, debounce state machine, stable level output, single-cycle rise/fall pulses.
- Sits between the board pins and counter20/clockgen in the top level.
- Clocked by the raw board clock.

Parameters:
- N_CH, 3, number of independent input channels.
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a change (10 ms at 50 MHz); legal range >= 1.
- REPEAT_CYCLES, 12500000, auto-repeat period; used only when AUTO_REPEAT_EN is defined.

Ports:
- clock  in  1  board clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- raw  in  N_CH  asynchronous switch/button inputs, active-high.
- level  out  N_CH  debounced stable level per channel.
- rise  out  N_CH  one-cycle pulse when level goes 0->1 (plus repeat pulses if enabled).
- fall  out  N_CH  one-cycle pulse when level goes 1->0.

Behaviour:
- Reset, sampled at the clock edge:
  - sync flops = 0, level = 0, rise = 0, fall = 0.
  - every channel enters IDLE_LO with its counter at 0.
  - reset mid-debounce discards the pending change; no pulse is emitted.
- Synchronizer: raw -> s1 -> s (two flops). s is the only signal the FSM sees.
- Per-channel FSM states: IDLE_LO, WAIT_HI, IDLE_HI, WAIT_LO.
  - IDLE_LO: if s=1, go to WAIT_HI with cnt=0.
  - WAIT_HI:
    - if s=0, return to IDLE_LO and clear cnt (glitch rejected, no pulse);
    - else if cnt == DEBOUNCE_CYCLES-1, go to IDLE_HI, set level=1, pulse rise for 1 cycle;
    - else cnt++.
  - IDLE_HI and WAIT_LO mirror the above, producing level=0 and a fall pulse.
- Latency: raw change first sampled at edge 0 -> s valid at edge 1 -> WAIT entered at edge 2 -> level and pulse update at edge 2+DEBOUNCE_CYCLES, provided the input is stable throughout.
- Outputs are registered. rise/fall are high exactly one cycle, coincident with the first cycle of the new level.
- Counter width is clog2(DEBOUNCE_CYCLES) bits, minimum 1. The counter never wraps: it is cleared on every WAIT exit.
- DEBOUNCE_CYCLES=1: level follows s one cycle after the WAIT state is entered.
- rise and fall are never both high on the same channel in the same cycle.
- Channels are fully independent; simultaneous events on different channels each produce their own pulses in the same cycle.

Optional Feature:
- Macro: SW_DEBOUNCER_AUTO_REPEAT_EN.
- Defined:
  - in IDLE_HI, a repeat counter runs from 0;
  - each time it reaches REPEAT_CYCLES-1 it emits a one-cycle rise pulse and restarts;
  - the counter is cleared on leaving IDLE_HI and on reset.
  - First repeat pulse: REPEAT_CYCLES cycles after the initial rise.
- Not defined: no repeat counter is instantiated; rise fires once per accepted 0->1 transition.

Decomposition:
- Package sw_debouncer_pkg holds:
  - the state enum {IDLE_LO, WAIT_HI, IDLE_HI, WAIT_LO} (2-bit encoding);
  - default constants DEBOUNCE_CYCLES_DEF and REPEAT_CYCLES_DEF;
  - a clog2-based width helper.
- One sub-module, debounce_ch: a single-channel synchronizer, FSM, counter and optional repeat logic.
- The top generates N_CH instances of debounce_ch.

Test Plan:
All tests use DEBOUNCE_CYCLES=4 and REPEAT_CYCLES=8.
- Reset: hold reset 2 cycles with raw=3'b111 -> level=0, rise=0, fall=0 throughout; first change is accepted only after reset deasserts.
- Clean press: raw[0] 0->1 at edge 0, held -> level[0]=1 and rise[0]=1 at edge 6; rise[0]=0 at edge 7.
- Glitch reject: raw[1] high for 3 cycles then low -> level[1] stays 0; rise[1] and fall[1] never assert.
- Bounce then settle: raw[2] toggles 1,0,1,0,1 on successive cycles, then holds 1 -> exactly one rise[2] pulse, 6 edges after the final 0->1.
- Release and simultaneity: raw[0] and raw[1] released together -> fall[0] and fall[1] pulse in the same cycle; level=0.
- Auto-repeat (macro defined), hold raw[0]=1:
  - rise[0] pulses at edges 6, 14 and 22;
  - releasing stops repeats, and fall[0] fires 6 edges after release.
  - With the macro undefined, the same stimulus gives only the pulse at edge 6.
